t_latch_toggle_sched: RTL and testbench

- Sequences toggle operations onto a bank of N T latches. The latches share one t line, and each latch has its own enb line.
- N requesters each own one latch. The block arbitrates between them round-robin.
- For each granted request it runs a safe setup/pulse/hold sequence on t and enb, so a latch is enabled only while t is stable.
- It keeps a shadow copy of the latch outputs and a count of completed toggles for the rest of the design.

---
 rtl/t_latch_toggle_sched.sv | 123 ++++++++++++
 tb/tb_t_latch_toggle_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/t_latch_toggle_sched.sv
// Round-robin toggle scheduler for a bank of T latches sharing one t line.
// Each grant runs setup/pulse/hold so enb is only raised while t is stable.
module t_latch_toggle_sched #(
  parameter int N         = 4,
  parameter int PULSE_CYC = 1,
  parameter int CNT_W     = 8,
  parameter logic [N-1:0] INIT_Q = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic             lat_t,
  output logic [N-1:0]     lat_enb,
  output logic [N-1:0]     q_shadow,
  output logic             busy,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PC_W  = 4;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [PC_W-1:0]    pcnt_q, pcnt_d;
  logic [N-1:0]       q_shadow_q, q_shadow_d;
  logic [CNT_W-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic               lat_t_q, lat_t_d;
  logic [N-1:0]       lat_enb_q, lat_enb_d;
  logic [N-1:0]       ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               found;
  logic [IDX_W-1:0]   idx;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    pcnt_d       = pcnt_q;
    q_shadow_d   = q_shadow_q;
    toggle_cnt_d = toggle_cnt_q;
    found        = 1'b0;
    idx          = '0;

    case (state_q)
      IDLE: begin
        // First requester at or above the pointer wins, wrapping at N.
        for (int i = 0; i < N; i++) begin
          idx = IDX_W'((int'(ptr_q) + i) % N);
          if (!found && req[idx]) begin
            found = 1'b1;
            g_d   = idx;
          end
        end
        if (found) begin
          if (g_d == IDX_W'(N - 1)) ptr_d = '0;
          else                      ptr_d = g_d + IDX_W'(1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        pcnt_d  = '0;
        state_d = PULSE;
      end
      PULSE: begin
        if (pcnt_q == PC_W'(PULSE_CYC - 1)) begin
          state_d           = HOLD;
          q_shadow_d[g_q]   = ~q_shadow_q[g_q];
          toggle_cnt_d      = toggle_cnt_q + CNT_W'(1);
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops.
    lat_t_d   = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
    lat_enb_d = '0;
    ack_d     = '0;
    if (state_d == PULSE) lat_enb_d[g_d] = 1'b1;
    if (state_d == HOLD)  ack_d[g_d]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      pcnt_q       <= '0;
      q_shadow_q   <= INIT_Q;
      toggle_cnt_q <= '0;
      lat_t_q      <= 1'b0;
      lat_enb_q    <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      pcnt_q       <= pcnt_d;
      q_shadow_q   <= q_shadow_d;
      toggle_cnt_q <= toggle_cnt_d;
      lat_t_q      <= lat_t_d;
      lat_enb_q    <= lat_enb_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign lat_t      = lat_t_q;
  assign lat_enb    = lat_enb_q;
  assign q_shadow   = q_shadow_q;
  assign busy       = busy_q;
  assign toggle_cnt = toggle_cnt_q;

endmodule

// File: tb/tb_t_latch_toggle_sched.sv
// Directed bench for t_latch_toggle_sched: default build plus PULSE_CYC=3
// and CNT_W=4 instances sharing clock and reset.
module tb_t_latch_toggle_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req, ack, lat_enb, q_shadow;
  logic       lat_t, busy;
  logic [7:0] toggle_cnt;

  logic [3:0] req_p3, ack_p3, enb_p3, q_p3;
  logic       t_p3, busy_p3;
  logic [7:0] cnt_p3;

  logic [3:0] req_c4, ack_c4, enb_c4, q_c4;
  logic       t_c4, busy_c4;
  logic [3:0] cnt_c4;

  int vecCount = 0;
  int missCount = 0;
  bit monOn = 1'b0;
  int pulses;

  logic [3:0] qTab [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};

  t_latch_toggle_sched #(.N(4), .PULSE_CYC(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .lat_t(lat_t),
    .lat_enb(lat_enb), .q_shadow(q_shadow), .busy(busy), .toggle_cnt(toggle_cnt));

  t_latch_toggle_sched #(.N(4), .PULSE_CYC(3), .CNT_W(8)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .req(req_p3), .ack(ack_p3), .lat_t(t_p3),
    .lat_enb(enb_p3), .q_shadow(q_p3), .busy(busy_p3), .toggle_cnt(cnt_p3));

  t_latch_toggle_sched #(.N(4), .PULSE_CYC(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .req(req_c4), .ack(ack_c4), .lat_t(t_c4),
    .lat_enb(enb_c4), .q_shadow(q_c4), .busy(busy_c4), .toggle_cnt(cnt_c4));

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) nextCycle();
    rst_n = 1'b1;
  endtask

  // Enable must never be high without t, and never more than one enable at once.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("enbWithoutT",    32'(!lat_t && (lat_enb != 4'b0)), 32'd0);
      checkOutput("enbOneHot",      32'($countones(lat_enb) > 1),    32'd0);
      checkOutput("enbWithoutT_p3", 32'(!t_p3 && (enb_p3 != 4'b0)),   32'd0);
      checkOutput("enbWithoutT_c4", 32'(!t_c4 && (enb_c4 != 4'b0)),   32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req = 4'b0; req_p3 = 4'b0; req_c4 = 4'b0;
    monOn = 1'b1;

    // Reset held with all requests pending.
    applyStimulus(4'b1111);
    repeat (3) begin
      nextCycle();
      checkOutput("rstLatT", 32'(lat_t), 32'd0);
      checkOutput("rstEnb",  32'(lat_enb), 32'd0);
      checkOutput("rstAck",  32'(ack), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstQ",    32'(q_shadow), 32'd0);
      checkOutput("rstCnt",  32'(toggle_cnt), 32'd0);
    end

    // Contention straight out of reset: grants 0,1,2,3,0,1.
    rst_n = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      nextCycle();
      checkOutput("contBusy", 32'(busy), 32'((c % 4) != 0));
      checkOutput("contEnb", 32'(lat_enb), ((c % 4) == 2) ? (32'd1 << ((c / 4) % 4)) : 32'd0);
      checkOutput("contAck", 32'(ack),     ((c % 4) == 3) ? (32'd1 << ((c / 4) % 4)) : 32'd0);
      if ((c % 4) == 3) begin
        checkOutput("contQ",   32'(q_shadow),   32'(qTab[c / 4]));
        checkOutput("contCnt", 32'(toggle_cnt), 32'(c / 4 + 1));
      end
      if (c == 23) applyStimulus(4'b0000);
    end

    // Single request on index 2.
    doReset();
    applyStimulus(4'b0100);
    checkOutput("sglLatT0", 32'(lat_t), 32'd0);
    checkOutput("sglBusy0", 32'(busy), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput("sglLatT", 32'(lat_t), 32'(c <= 3));
      checkOutput("sglBusy", 32'(busy),  32'(c <= 3));
      checkOutput("sglEnb",  32'(lat_enb), (c == 2) ? 32'h4 : 32'h0);
      checkOutput("sglAck",  32'(ack),     (c == 3) ? 32'h4 : 32'h0);
      checkOutput("sglQ",    32'(q_shadow),   (c >= 3) ? 32'h4 : 32'h0);
      checkOutput("sglCnt",  32'(toggle_cnt), (c >= 3) ? 32'd1 : 32'd0);
      if (c == 3) applyStimulus(4'b0000);
    end

    // Double toggle of latch 1.
    doReset();
    applyStimulus(4'b0010);
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      if (lat_enb[1]) pulses++;
      if (c == 3) begin
        checkOutput("dblQ1", 32'(q_shadow), 32'h2);
        applyStimulus(4'b0000);
      end
      if (c == 4) applyStimulus(4'b0010);
      if (c == 7) begin
        checkOutput("dblQ2", 32'(q_shadow), 32'h0);
        applyStimulus(4'b0000);
      end
    end
    checkOutput("dblPulses", 32'(pulses), 32'd2);
    checkOutput("dblCnt",    32'(toggle_cnt), 32'd2);
    checkOutput("dblBusy",   32'(busy), 32'd0);

    // Reset asserted during the PULSE of a req[3] sequence.
    doReset();
    applyStimulus(4'b1000);
    nextCycle();
    nextCycle();
    checkOutput("abtEnbPre", 32'(lat_enb), 32'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("abtEnbAsync", 32'(lat_enb), 32'h0);
    checkOutput("abtTAsync",   32'(lat_t),   32'd0);
    applyStimulus(4'b0000);
    repeat (3) begin
      nextCycle();
      checkOutput("abtAck",  32'(ack), 32'd0);
      checkOutput("abtQ",    32'(q_shadow), 32'd0);
      checkOutput("abtBusy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    nextCycle();
    checkOutput("abtIdle", 32'(busy), 32'd0);

    // Pointer returns to 0 on reset: grant 1 moves it to 2, reset, then 0110 must pick 1.
    applyStimulus(4'b0010);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      if (c == 3) applyStimulus(4'b0000);
    end
    doReset();
    applyStimulus(4'b0110);
    nextCycle();
    nextCycle();
    checkOutput("ptrRstEnb", 32'(lat_enb), 32'h2);
    nextCycle();
    checkOutput("ptrRstAck", 32'(ack), 32'h2);
    applyStimulus(4'b0000);
    nextCycle();

    // PULSE_CYC=3: enable for three cycles, ack at cycle 5.
    doReset();
    req_p3 = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      checkOutput("p3Enb",  32'(enb_p3), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
      checkOutput("p3Ack",  32'(ack_p3), (c == 5) ? 32'h1 : 32'h0);
      checkOutput("p3LatT", 32'(t_p3),   32'(c >= 1 && c <= 5));
      checkOutput("p3Q",    32'(q_p3),   (c >= 5) ? 32'h1 : 32'h0);
      if (c == 5) req_p3 = 4'b0000;
    end

    // CNT_W=4: sixteen toggles wrap the counter back to 0.
    doReset();
    req_c4 = 4'b0001;
    for (int c = 1; c <= 66; c++) begin
      nextCycle();
      if (c == 3)  checkOutput("c4Cnt1",  32'(cnt_c4), 32'd1);
      if (c == 59) checkOutput("c4Cnt15", 32'(cnt_c4), 32'd15);
      if (c == 63) begin
        checkOutput("c4Wrap", 32'(cnt_c4), 32'd0);
        checkOutput("c4Ack",  32'(ack_c4), 32'h1);
        req_c4 = 4'b0000;
      end
    end
    checkOutput("c4Q", 32'(q_c4), 32'h0);

    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
